shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL use one clock and one reset, both listed first: clk input 1 rising-edge clock; rst input 1 reset, asynchronous, active-high.
REQ-002 The block SHALL have per requester k in {0,1}: in_valid_k input 1 request present.
REQ-003 The block SHALL have in_ready_k output 1 request accepted this cycle.
REQ-004 The block SHALL have in_data_k input 8 operand.
REQ-005 The block SHALL have in_amt_k input 5 shift amount 0..31.
REQ-006 The block SHALL have in_rot_k, in_ar_k, in_lr_k inputs 1 each: rotate; arithmetic; direction (1 = left, 0 = right).
REQ-007 The block SHALL have res_valid output 1 result present.
REQ-008 The block SHALL have res_ready input 1 consumer takes the result.
REQ-009 The block SHALL have res_data output 8 result.
REQ-010 The block SHALL have res_id output 1 index of the requester that owns the result.
REQ-011 The block SHALL have busy output 1, high whenever state != IDLE.

Function
REQ-012 The block SHALL contain exactly one 8-bit shift datapath instance (amount 0..8 per pass), shared by both requesters.
REQ-013 The block SHALL implement states IDLE, BUSY and DONE.
REQ-014 In IDLE, grant SHALL be: the only valid requester; if both are valid, the requester not served last; last-served pointer resets to 1 so requester 0 wins first.
REQ-015 in_ready_k SHALL equal (state==IDLE) && in_valid_k && grant==k, and SHALL be 0 in BUSY and DONE.
REQ-016 On accept, the block SHALL latch the operand, mode bits, rem=amt and id, set last=k, and go to BUSY.
REQ-017 Each BUSY cycle SHALL apply step=min(rem,8) to the operand register and set rem-=step.
REQ-018 When the post-step rem equals 0, the block SHALL go to DONE.
REQ-019 amt=0 SHALL take exactly one pass with step 0, returning the operand unchanged.
REQ-020 Passes SHALL be P=max(1,ceil(amt/8)); res_valid SHALL rise P cycles after the accepting edge.
REQ-021 Pass semantics: rot rotates in direction lr. When rot=0, logical shifts fill 0, and arithmetic right (ar=1, lr=0) fills with the bit 7 held at that pass. ar is ignored when lr=1 or rot=1. Step 8 logical gives 0x00, step 8 arithmetic right gives all sign bits, step 8 rotate gives identity.
REQ-022 In DONE, res_valid=1 and res_data/res_id SHALL stay stable until res_ready=1.
REQ-023 On the handshake edge the block SHALL return to IDLE; no new request is accepted in the same cycle as the handshake.
REQ-024 in_* changes while in BUSY or DONE SHALL have no effect on the in-flight operation.
REQ-025 A requester holding in_valid without ready SHALL keep its request pending; the block SHALL never drop it.
REQ-026 res_data SHALL be 0x00 and res_id SHALL be 0 whenever res_valid=0.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, rem=0, operand=0x00, last=1, and res_valid=busy=res_id=0, res_data=0x00, in_ready_k=0, regardless of clk.
REQ-028 Reset asserted mid-BUSY or in DONE SHALL abort the operation; no result SHALL appear after release.
REQ-029 The first rising edge after rst falls SHALL be able to accept a request.

Verification
REQ-030 Rotate: req0 data=0x81 amt=1 rot=1 lr=1 -> res_data=0x03, res_id=0, res_valid 1 cycle after accept.
REQ-031 Multi-pass arithmetic: req1 data=0x90 amt=20 ar=1 lr=0 -> passes 8, 8, 4 -> res_data=0xFF, res_id=1, res_valid 3 cycles after accept.
REQ-032 Boundary: logical left 0x01 amt=9 -> 0x00 (2 passes). Rotate left 0x01 amt=9 -> 0x02. amt=0 on 0x5A -> 0x5A after 1 cycle.
REQ-033 Fairness: both valid continuously from reset -> grants alternate 0, 1, 0, 1. Only req1 valid twice -> req1 granted both times.
REQ-034 Backpressure: hold res_ready=0 for 5 cycles in DONE -> res_data/res_id stable, in_ready_0/1=0, busy=1; release -> IDLE next edge.
REQ-035 Reset: assert rst in the 2nd BUSY cycle of amt=20 -> all outputs 0 immediately, no res_valid after release, next request served normally.

Source files
------------

// File: rtl/shift_arbiter.sv
// Two-requester shift/rotate arbiter.
// Both requesters share one 8-bit shifter. The shifter moves at most 8 bits per cycle,
// so a long shift amount takes several passes over the operand register.
// The result is held until the consumer takes it. Only after that can a new request be granted.

// One pass of the shared datapath: shift or rotate by 0..8 positions.
module shift_arbiter_shifter (
    input  logic [7:0] i_data,
    input  logic [3:0] i_step,
    input  logic       i_rot,
    input  logic       i_ar,
    input  logic       i_lr,
    output logic [7:0] o_data
);
    logic [3:0] w_inv;
    logic [7:0] w_rotl;
    logic [7:0] w_rotr;
    logic [7:0] w_lsl;
    logic [7:0] w_lsr;
    logic [7:0] w_asr;

    // A rotate by 0 or 8 is the identity.
    // A logical shift by 8 clears the operand.
    // An arithmetic right shift by 8 replicates the sign bit.
    assign w_inv  = 4'd8 - i_step;
    assign w_rotl = (i_data << i_step) | (i_data >> w_inv);
    assign w_rotr = (i_data >> i_step) | (i_data << w_inv);
    assign w_lsl  = i_data << i_step;
    assign w_lsr  = i_data >> i_step;
    assign w_asr  = $unsigned($signed(i_data) >>> i_step);

    // Pick the operation; ar only matters for a non-rotating right shift.
    always_comb begin
        o_data = w_lsr;
        if (i_rot)
            o_data = i_lr ? w_rotl : w_rotr;
        else if (i_lr)
            o_data = w_lsl;
        else if (i_ar)
            o_data = w_asr;
    end
endmodule

module shift_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid_0,
    output logic       in_ready_0,
    input  logic [7:0] in_data_0,
    input  logic [4:0] in_amt_0,
    input  logic       in_rot_0,
    input  logic       in_ar_0,
    input  logic       in_lr_0,
    input  logic       in_valid_1,
    output logic       in_ready_1,
    input  logic [7:0] in_data_1,
    input  logic [4:0] in_amt_1,
    input  logic       in_rot_1,
    input  logic       in_ar_1,
    input  logic       in_lr_1,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_id,
    output logic       busy
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t     r_state;
    logic [7:0] r_opnd;
    logic [4:0] r_rem;
    logic       r_rot;
    logic       r_ar;
    logic       r_lr;
    logic       r_id;
    logic       r_last;

    logic       w_grant;
    logic       w_accept;
    logic [3:0] w_step;
    logic [4:0] w_rem_nxt;
    logic [7:0] w_shifted;

    // Round-robin grant.
    // A lone requester always wins.
    // On a tie, the requester that was not served last wins.
    assign w_grant  = (in_valid_0 && in_valid_1) ? ~r_last : in_valid_1;
    assign w_accept = (r_state == S_IDLE) && !rst && (in_valid_0 || in_valid_1);

    // Ready is combinational so a request is accepted in the same cycle it is granted.
    // It is gated by rst so nothing looks accepted while reset is held.
    assign in_ready_0 = w_accept && in_valid_0 && !w_grant;
    assign in_ready_1 = w_accept && in_valid_1 && w_grant;

    // Each pass consumes up to 8 positions of the remaining amount.
    assign w_step    = (r_rem > 5'd8) ? 4'd8 : r_rem[3:0];
    assign w_rem_nxt = r_rem - {1'b0, w_step};

    shift_arbiter_shifter u_shift (
        .i_data (r_opnd),
        .i_step (w_step),
        .i_rot  (r_rot),
        .i_ar   (r_ar),
        .i_lr   (r_lr),
        .o_data (w_shifted)
    );

    // Control FSM: latch on accept, iterate passes in BUSY, hold result in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_opnd  <= 8'h00;
            r_rem   <= 5'd0;
            r_rot   <= 1'b0;
            r_ar    <= 1'b0;
            r_lr    <= 1'b0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_opnd  <= w_grant ? in_data_1 : in_data_0;
                        r_rem   <= w_grant ? in_amt_1  : in_amt_0;
                        r_rot   <= w_grant ? in_rot_1  : in_rot_0;
                        r_ar    <= w_grant ? in_ar_1   : in_ar_0;
                        r_lr    <= w_grant ? in_lr_1   : in_lr_0;
                        r_id    <= w_grant;
                        r_last  <= w_grant;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // An amount of 0 still takes one pass with step 0.
                    r_opnd <= w_shifted;
                    r_rem  <= w_rem_nxt;
                    if (w_rem_nxt == 5'd0)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The result bus reads as zero whenever no result is offered.
    assign res_valid = (r_state == S_DONE);
    assign res_data  = res_valid ? r_opnd : 8'h00;
    assign res_id    = res_valid ? r_id : 1'b0;
    assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter.
// A table of single-requester operations is checked through an expected-result queue.
// Hand-written sequences cover fairness, backpressure and reset during an operation.
module tb_shift_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid_0 = 0, in_valid_1 = 0;
    logic       in_ready_0, in_ready_1;
    logic [7:0] in_data_0 = 0, in_data_1 = 0;
    logic [4:0] in_amt_0 = 0, in_amt_1 = 0;
    logic       in_rot_0 = 0, in_ar_0 = 0, in_lr_0 = 0;
    logic       in_rot_1 = 0, in_ar_1 = 0, in_lr_1 = 0;
    logic       res_valid, res_ready = 0, res_id, busy;
    logic [7:0] res_data;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit         k;
        logic [7:0] d;
        logic [4:0] amt;
        bit         rot, ar, lr;
        logic [7:0] exp;
        int         p;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        bit         id;
        int         p;
    } exp_t;

    vec_t vecs[13];
    exp_t exp_q[$];

    shift_arbiter dut (
        .clk(clk), .rst(rst),
        .in_valid_0(in_valid_0), .in_ready_0(in_ready_0), .in_data_0(in_data_0),
        .in_amt_0(in_amt_0), .in_rot_0(in_rot_0), .in_ar_0(in_ar_0), .in_lr_0(in_lr_0),
        .in_valid_1(in_valid_1), .in_ready_1(in_ready_1), .in_data_1(in_data_1),
        .in_amt_1(in_amt_1), .in_rot_1(in_rot_1), .in_ar_1(in_ar_1), .in_lr_1(in_lr_1),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit k, input bit v, input logic [7:0] d, input logic [4:0] amt,
                           input bit rot, input bit ar, input bit lr);
        if (k) begin
            in_valid_1 = v; in_data_1 = d; in_amt_1 = amt;
            in_rot_1 = rot; in_ar_1 = ar; in_lr_1 = lr;
        end else begin
            in_valid_0 = v; in_data_0 = d; in_amt_0 = amt;
            in_rot_0 = rot; in_ar_0 = ar; in_lr_0 = lr;
        end
    endtask

    function automatic bit rdy(input bit k);
        return k ? in_ready_1 : in_ready_0;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_id"}, res_id, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Drive one request (call at a negedge), wait for grant, then watch for the result.
    // hs=1 completes the result handshake; hs=0 leaves the block holding the result.
    task automatic run_op(input vec_t v, input bit hs, input string tag);
        int   w;
        int   lat;
        exp_t e;
        set_req(v.k, 1, v.d, v.amt, v.rot, v.ar, v.lr);
        #1;
        w = 0;
        while (!rdy(v.k) && w < 20) begin
            @(negedge clk); #1; w++;
        end
        chk({tag, "_granted"}, rdy(v.k), 1);
        if (!rdy(v.k)) begin
            set_req(v.k, 0, 0, 0, 0, 0, 0);
            return;
        end
        exp_q.push_back('{d: v.exp, id: v.k, p: v.p});
        @(posedge clk); #1;
        // Scribble on the inputs; the in-flight operation must not notice.
        set_req(v.k, 0, 8'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        chk({tag, "_busy_after_accept"}, busy, 1);
        chk({tag, "_ready_low_busy"}, rdy(v.k), 0);
        lat = 0;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
        end while (!res_valid && lat < 40);
        chk({tag, "_res_valid"}, res_valid, 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk({tag, "_data"}, res_data, e.d);
        chk({tag, "_id"}, res_id, e.id);
        chk({tag, "_latency"}, lat, e.p);
        if (hs) begin
            res_ready = 1;
            @(posedge clk); #1;
            res_ready = 0;
            check_idle_outputs({tag, "_post"});
            @(negedge clk);
        end
    endtask

    initial begin
        int   g[$];
        int   w;
        int   seen;
        vec_t bp;

        vecs[0]  = '{0, 8'h81, 5'd1,  1, 0, 1, 8'h03, 1};
        vecs[1]  = '{1, 8'h90, 5'd20, 0, 1, 0, 8'hFF, 3};
        vecs[2]  = '{0, 8'h01, 5'd9,  0, 0, 1, 8'h00, 2};
        vecs[3]  = '{0, 8'h01, 5'd9,  1, 0, 1, 8'h02, 2};
        vecs[4]  = '{1, 8'h5A, 5'd0,  0, 0, 0, 8'h5A, 1};
        vecs[5]  = '{0, 8'hB4, 5'd3,  0, 0, 0, 8'h16, 1};
        vecs[6]  = '{1, 8'hB4, 5'd3,  0, 1, 0, 8'hF6, 1};
        vecs[7]  = '{0, 8'h3C, 5'd8,  1, 0, 0, 8'h3C, 1};
        vecs[8]  = '{1, 8'h96, 5'd31, 0, 0, 1, 8'h00, 4};
        vecs[9]  = '{0, 8'h96, 5'd12, 1, 0, 0, 8'h69, 2};
        vecs[10] = '{1, 8'h03, 5'd5,  0, 1, 1, 8'h60, 1};
        vecs[11] = '{0, 8'h80, 5'd16, 0, 1, 0, 8'hFF, 2};
        vecs[12] = '{1, 8'h41, 5'd7,  1, 1, 0, 8'h82, 1};

        // Reset state, with requests present; nothing may look accepted.
        in_valid_0 = 1; in_valid_1 = 1;
        #3;
        check_idle_outputs("reset");
        chk("reset_ready0", in_ready_0, 0);
        chk("reset_ready1", in_ready_1, 0);
        repeat (2) @(negedge clk);

        // Fairness: both requesters valid continuously from reset.
        set_req(0, 1, 8'h11, 5'd0, 0, 0, 0);
        set_req(1, 1, 8'h22, 5'd0, 0, 0, 0);
        res_ready = 1;
        rst = 0;
        w = 0;
        while (g.size() < 4 && w < 60) begin
            #1;
            if (in_ready_0 && in_ready_1) g.push_back(2);
            else if (in_ready_0) g.push_back(0);
            else if (in_ready_1) g.push_back(1);
            @(negedge clk); w++;
        end
        chk("fair_count", g.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("fair_grant%0d", i), (i < g.size()) ? g[i] : -1, i % 2);
        set_req(0, 0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0, 0);
        repeat (6) @(negedge clk);
        res_ready = 0;
        #1;
        check_idle_outputs("fair_drain");
        @(negedge clk);

        // Table of single operations.
        for (int i = 0; i < 13; i++)
            run_op(vecs[i], 1, $sformatf("vec%0d", i));

        // Only req1 valid, twice in a row: granted both times.
        run_op(vecs[4], 1, "solo1_a");
        run_op(vecs[6], 1, "solo1_b");

        // Backpressure: hold the result for 5 cycles while both requesters wait.
        bp = '{0, 8'hC3, 5'd10, 1, 0, 0, 8'hF0, 2};
        run_op(bp, 0, "bp");
        set_req(0, 1, 8'hAA, 5'd1, 0, 0, 1);
        set_req(1, 1, 8'hBB, 5'd1, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk($sformatf("bp_data%0d", i), res_data, 8'hF0);
            chk($sformatf("bp_id%0d", i), res_id, 0);
            chk($sformatf("bp_rdy%0d", i), {in_ready_1, in_ready_0}, 0);
            chk($sformatf("bp_busy%0d", i), busy, 1);
        end
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
        // Handshake edge returns to IDLE without taking the waiting requests.
        chk("bp_release_busy", busy, 0);
        chk("bp_release_valid", res_valid, 0);
        set_req(0, 0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Reset in the second BUSY cycle of a 3-pass operation.
        set_req(1, 1, 8'h90, 5'd20, 0, 1, 0);
        #1;
        w = 0;
        while (!in_ready_1 && w < 20) begin
            @(negedge clk); #1; w++;
        end
        chk("rst_op_granted", in_ready_1, 1);
        @(posedge clk); #1;
        set_req(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        rst = 1;
        in_valid_0 = 1;
        #1;
        check_idle_outputs("midrst");
        chk("midrst_ready0", in_ready_0, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        // First edge after release can accept.
        chk("post_rst_ready0", in_ready_0, 1);
        in_valid_0 = 0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (res_valid || busy) seen++;
        end
        chk("aborted_no_result", seen, 0);
        run_op(vecs[0], 1, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
